// File: rtl/attack_wave_sched_pkg.sv
// Shared definitions for the dodge-game flow controller:
// game states, raster timing constants and default scheduling parameters.
package attack_wave_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PLAY,
        OVER
    } game_state_t;

    // 1024x768 @ 65 MHz raster timing
    localparam int HSP = 136;
    localparam int HBP = 160;
    localparam int HFP = 24;
    localparam int VSP = 6;
    localparam int VBP = 29;
    localparam int VFP = 3;

    localparam int DEF_N_ATK        = 6;
    localparam int DEF_SPAWN_FRAMES = 60;
    localparam int DEF_LEVEL_FRAMES = 600;
    localparam int DEF_MAX_LEVEL    = 7;

endpackage

// File: rtl/frame_divider.sv
// Frame counter with enable and synchronous clear.
// wrap pulses on the enabled cycle where the count returns to zero.
module frame_divider #(
    parameter int W     = 10,
    parameter int LIMIT = 60
) (
    input  logic clk_65M,
    input  logic clear,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (clr || wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/attack_wave_sched.sv
// Game-flow controller: IDLE/ARM/PLAY/OVER sequencing, attacker release
// schedule, game-over aggregation, level and survival score for the HUD.
module attack_wave_sched
    import attack_wave_sched_pkg::*;
#(
    parameter int N_ATK        = DEF_N_ATK,
    parameter int SPAWN_FRAMES = DEF_SPAWN_FRAMES,
    parameter int LEVEL_FRAMES = DEF_LEVEL_FRAMES,
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int FCNT_W       = 10
) (
    input  logic             clk_65M,
    input  logic             clear,
    input  logic             start_btn,
    input  logic [16:0]      H_count,
    input  logic [16:0]      V_count,
    input  logic [N_ATK-1:0] atk_over,
    output logic             game_stop,
    output logic             game_on,
    output logic [N_ATK-1:0] atk_enable,
    output logic [2:0]       level,
    output logic [15:0]      score,
    output logic             frame_tick
);

    localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);

    game_state_t      state_q, state_n;
    logic             start_q, start_ok;
    logic             ft, st, hit, adv, arm_entry;
    logic             spawn_wrap, level_wrap;
    logic [N_ATK-1:0] atk_enable_n;
    logic [2:0]       level_n;
    logic [15:0]      score_n;

    assign ft  = (H_count == '0) && (V_count == '0);
    // start_ok masks the first cycle after clear so a held button is no edge
    assign st  = start_btn & ~start_q & start_ok;
    assign hit = |(atk_over & atk_enable);

    always_comb begin
        state_n   = state_q;
        arm_entry = 1'b0;
        adv       = 1'b0;
        unique case (state_q)
            IDLE: if (st) begin
                state_n   = ARM;
                arm_entry = 1'b1;
            end
            ARM: if (ft) state_n = PLAY;
            PLAY: begin
                if (hit) state_n = OVER;
                else if (ft) adv = 1'b1;
            end
            OVER: if (st) begin
                state_n   = ARM;
                arm_entry = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        atk_enable_n = atk_enable;
        level_n      = level;
        score_n      = score;
        if (arm_entry) begin
            atk_enable_n = '0;
            level_n      = '0;
            score_n      = '0;
        end else if (state_q == ARM && ft) begin
            atk_enable_n = N_ATK'(1);
        end else if (adv) begin
            if (score != 16'hFFFF) score_n = score + 16'd1;
            if (spawn_wrap) atk_enable_n = (atk_enable << 1) | N_ATK'(1);
            if (level_wrap && level != LVL_MAX) level_n = level + 3'd1;
        end
    end

    frame_divider #(.W(FCNT_W), .LIMIT(SPAWN_FRAMES)) u_spawn (
        .clk_65M (clk_65M),
        .clear   (clear),
        .clr     (arm_entry),
        .en      (adv),
        .wrap    (spawn_wrap)
    );

    frame_divider #(.W(FCNT_W), .LIMIT(LEVEL_FRAMES)) u_level (
        .clk_65M (clk_65M),
        .clear   (clear),
        .clr     (arm_entry),
        .en      (adv),
        .wrap    (level_wrap)
    );

    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            start_ok   <= 1'b0;
            frame_tick <= 1'b0;
            game_stop  <= 1'b1;
            game_on    <= 1'b0;
            atk_enable <= '0;
            level      <= '0;
            score      <= '0;
        end else begin
            state_q    <= state_n;
            start_q    <= start_btn;
            start_ok   <= 1'b1;
            frame_tick <= ft;
            game_stop  <= (state_n == IDLE) || (state_n == ARM);
            game_on    <= (state_n == PLAY);
            atk_enable <= atk_enable_n;
            level      <= level_n;
            score      <= score_n;
        end
    end

endmodule

// File: tb/tb_attack_wave_sched.sv
// Directed bench for attack_wave_sched using a short 4-cycle raster
// (H_count 0..3, V_count 0) so each frame is four clocks.
module tb_attack_wave_sched;
    import attack_wave_sched_pkg::*;

    logic        clk_65M = 1'b0;
    logic        clear;
    logic        start_btn;
    logic [16:0] H_count;
    logic [16:0] V_count;
    logic [5:0]  atk_over;
    logic        game_stop;
    logic        game_on;
    logic [5:0]  atk_enable;
    logic [2:0]  level;
    logic [15:0] score;
    logic        frame_tick;

    int vec  = 0;
    int miss = 0;

    always #5 clk_65M = ~clk_65M;

    attack_wave_sched dut (
        .clk_65M    (clk_65M),
        .clear      (clear),
        .start_btn  (start_btn),
        .H_count    (H_count),
        .V_count    (V_count),
        .atk_over   (atk_over),
        .game_stop  (game_stop),
        .game_on    (game_on),
        .atk_enable (atk_enable),
        .level      (level),
        .score      (score),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_65M);
        #1;
        H_count = (H_count == 17'd3) ? 17'd0 : H_count + 17'd1;
    endtask

    task automatic frames(input int n);
        repeat (n * 4) cyc();
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        for (int i = 0; i < 8 && dut.state_q != PLAY; i++) cyc();
        chk("arm_to_play", 32'(dut.state_q), 32'(PLAY));
    endtask

    initial begin
        logic [5:0] exp_en;
        clear     = 1'b1;
        start_btn = 1'b0;
        H_count   = 17'd1;
        V_count   = 17'd0;
        atk_over  = '0;
        cyc();
        cyc();
        chk("rst_stop", 32'(game_stop), 32'd1);
        chk("rst_on", 32'(game_on), 32'd0);
        chk("rst_en", 32'(atk_enable), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_ftick", 32'(frame_tick), 32'd0);
        clear = 1'b0;

        for (int f = 0; f < 3; f++) begin
            frames(1);
            chk("idle_stop", 32'(game_stop), 32'd1);
            chk("idle_on", 32'(game_on), 32'd0);
            chk("idle_en", 32'(atk_enable), 32'd0);
            chk("idle_score", 32'(score), 32'd0);
        end
        while (H_count != 17'd0) cyc();
        cyc();
        chk("ftick_hi", 32'(frame_tick), 32'd1);
        cyc();
        chk("ftick_lo", 32'(frame_tick), 32'd0);

        while (H_count != 17'd2) cyc();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        chk("arm_state", 32'(dut.state_q), 32'(ARM));
        chk("arm_stop", 32'(game_stop), 32'd1);
        chk("arm_on", 32'(game_on), 32'd0);
        while (H_count != 17'd0) cyc();
        chk("arm_hold_stop", 32'(game_stop), 32'd1);
        cyc();
        chk("play_on", 32'(game_on), 32'd1);
        chk("play_stop", 32'(game_stop), 32'd0);
        chk("play_en0", 32'(atk_enable), 32'h01);
        chk("play_ftick", 32'(frame_tick), 32'd1);
        chk("play_score0", 32'(score), 32'd0);

        exp_en = 6'h01;
        for (int k = 1; k <= 6; k++) begin
            frames(60);
            exp_en = (exp_en << 1) | 6'h01;
            chk("spawn_en", 32'(atk_enable), 32'(exp_en));
            chk("spawn_score", 32'(score), 32'(60 * k));
        end

        frames(239);
        chk("level_599", 32'(level), 32'd0);
        frames(1);
        chk("level_600", 32'(level), 32'd1);
        chk("score_600", 32'(score), 32'd600);
        for (int l = 2; l <= 8; l++) begin
            frames(600);
            chk("level_step", 32'(level), 32'((l > 7) ? 7 : l));
        end
        chk("score_4800", 32'(score), 32'd4800);

        force dut.score = 16'hFFFD;
        cyc();
        release dut.score;
        frames(1);
        chk("score_fffe", 32'(score), 32'hFFFE);
        frames(1);
        chk("score_ffff", 32'(score), 32'hFFFF);
        frames(1);
        chk("score_sat", 32'(score), 32'hFFFF);

        atk_over = 6'h20;
        cyc();
        chk("over1_state", 32'(dut.state_q), 32'(OVER));
        chk("over1_on", 32'(game_on), 32'd0);
        chk("over1_stop", 32'(game_stop), 32'd0);
        frames(2);
        chk("over1_score", 32'(score), 32'hFFFF);
        chk("over1_level", 32'(level), 32'd7);
        chk("over1_en", 32'(atk_enable), 32'h3F);
        atk_over = '0;

        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        chk("rearm_state", 32'(dut.state_q), 32'(ARM));
        chk("rearm_stop", 32'(game_stop), 32'd1);
        chk("rearm_level", 32'(level), 32'd0);
        chk("rearm_score", 32'(score), 32'd0);
        chk("rearm_en", 32'(atk_enable), 32'd0);
        for (int i = 0; i < 8 && dut.state_q != PLAY; i++) cyc();
        chk("g2_play", 32'(dut.state_q), 32'(PLAY));

        frames(60);
        chk("g2_en", 32'(atk_enable), 32'h03);
        chk("g2_score", 32'(score), 32'd60);
        atk_over = 6'h20;
        frames(2);
        chk("mask_state", 32'(dut.state_q), 32'(PLAY));
        chk("mask_on", 32'(game_on), 32'd1);
        chk("mask_score", 32'(score), 32'd62);
        atk_over = '0;
        while (H_count != 17'd0) cyc();
        atk_over = 6'h01;
        cyc();
        chk("hitft_state", 32'(dut.state_q), 32'(OVER));
        chk("hitft_on", 32'(game_on), 32'd0);
        chk("hitft_score", 32'(score), 32'd62);
        chk("hitft_ftick", 32'(frame_tick), 32'd1);
        frames(1);
        chk("hitft_frozen", 32'(score), 32'd62);
        atk_over = '0;

        start_game();
        frames(5);
        chk("g3_score", 32'(score), 32'd5);
        chk("g3_ftick", 32'(frame_tick), 32'd1);
        #3;
        clear = 1'b1;
        #1;
        chk("clr_stop", 32'(game_stop), 32'd1);
        chk("clr_on", 32'(game_on), 32'd0);
        chk("clr_en", 32'(atk_enable), 32'd0);
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_score", 32'(score), 32'd0);
        chk("clr_ftick", 32'(frame_tick), 32'd0);
        chk("clr_state", 32'(dut.state_q), 32'(IDLE));
        start_btn = 1'b1;
        cyc();
        cyc();
        clear = 1'b0;
        frames(2);
        chk("held_btn_state", 32'(dut.state_q), 32'(IDLE));
        chk("held_btn_stop", 32'(game_stop), 32'd1);
        start_btn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/attack_wave_sched.md
# attack_wave_sched

Game-flow controller for the dodge game on the 1024x768 / 65 MHz display pipeline. It owns the IDLE/ARM/PLAY/OVER sequence and drives the shared `game_stop` / `game_on` controls into the attacker modules. It releases attackers one at a time on a frame schedule, aggregates their per-attacker game-over flags, and keeps a difficulty level and a survival score for the HUD.

## Interface
Parameters:
- `N_ATK`, default 6: number of attacker instances served.
- `SPAWN_FRAMES`, default 60: frames between successive attacker releases.
- `LEVEL_FRAMES`, default 600: frames per level step.
- `MAX_LEVEL`, default 7: level saturation value.
- `FCNT_W`, default 10: width of the spawn and level frame counters. Must hold `LEVEL_FRAMES-1`.

Ports:
- `clk_65M`, in, 1: pixel clock; the only clock.
- `clear`, in, 1: **reset, asynchronous, active-high**.
- `start_btn`, in, 1: start/restart request, already synchronised; rising-edge detected internally.
- `H_count`, in, 17: horizontal raster count.
- `V_count`, in, 17: vertical raster count.
- `atk_over`, in, `N_ATK`: per-attacker game-over flags, bit i from attacker i+1.
- `game_stop`, out, 1: holds all attackers at their start positions and clears their over latches.
- `game_on`, out, 1: high only in PLAY.
- `atk_enable`, out, `N_ATK`: per-attacker release mask; the top level ANDs it into `atkN_on` and the over aggregation.
- `level`, out, 3: current difficulty, 0..`MAX_LEVEL`.
- `score`, out, 16: frames survived in the current game, saturating.
- `frame_tick`, out, 1: registered one-cycle pulse per frame.

## Operation
- Frame tick: `ft = (H_count==0 && V_count==0)`. The internal `ft` is combinational. The output `frame_tick` is `ft` delayed one cycle.
- Start edge: `st = start_btn & ~start_q`, where `start_q` is registered `start_btn`.
- States: IDLE, ARM, PLAY, OVER.
- IDLE:
  - Outputs: `game_stop`=1, `game_on`=0, `atk_enable`=0.
  - On `st`, go to ARM.
- ARM:
  - `game_stop` stays 1 until the next `ft`, so every attacker sees at least one full frame of stop and reloads its start position.
  - Counters are zeroed on entry.
  - On `ft`: go to PLAY, and set `atk_enable`=1 (attacker 0 only).
- PLAY:
  - Outputs: `game_stop`=0, `game_on`=1.
  - On each `ft`:
    - `score` += 1, saturating at 0xFFFF.
    - Spawn counter += 1. When it reaches `SPAWN_FRAMES`-1 it wraps to 0 and `atk_enable` becomes `(atk_enable<<1)|1`. Once the mask is all ones the shift is held.
    - Level counter wraps at `LEVEL_FRAMES`-1. On each wrap `level` += 1, saturating at `MAX_LEVEL`.
  - If `|(atk_over & atk_enable)` is 1, go to OVER.
- OVER:
  - Outputs: `game_on`=0, `game_stop`=0, so attacker over latches stay visible.
  - `atk_enable`, `level` and `score` are frozen for display.
  - `atk_over` is ignored.
  - On `st`, go to ARM.
- Entry to ARM from either IDLE or OVER zeroes `atk_enable`, `level`, `score` and both counters in the same cycle.
- Priorities:
  - In PLAY, over beats `ft` in the same cycle: no score or level update, go straight to OVER.
  - In PLAY, `st` is ignored.
  - In ARM, `st` is ignored.
  - `atk_over` bits outside `atk_enable` are ignored in every state.

## Timing
- All outputs are registered.
- State-derived outputs change one cycle after the triggering input:
  - `st` → `game_stop`=1 on the next edge.
  - `ft` in ARM → `game_stop`=0 and `game_on`=1 on the next edge.
  - Over detected → `game_on`=0 on the next edge.
- Attackers use the same raster `ft`. Release at `ft` therefore takes effect from the following frame's movement tick.
- Reset values: state IDLE, `game_stop`=1, `game_on`=0, `atk_enable`=0, `level`=0, `score`=0, `frame_tick`=0, `start_q`=0, counters 0.
- `clear` asserted mid-game returns everything to the reset values immediately (asynchronous); no `ft` is needed.
- A `start_btn` already high at release of `clear` produces no start.

## Structure
- Shared game package holds:
  - the state enum `{IDLE, ARM, PLAY, OVER}`;
  - the raster constants HBP, HFP, VBP, VFP, HSP, VSP;
  - the default `N_ATK`, `SPAWN_FRAMES`, `LEVEL_FRAMES`, `MAX_LEVEL`.
- One sub-module, `frame_divider`: a parameterised counter with enable, clear and wrap pulse. It is instanced twice, for spawn and for level.

## Test plan
1. Reset with `start_btn`=0, run 3 frames → `game_stop`=1, `game_on`=0, `atk_enable`=0, `score`=0 throughout.
2. Pulse `start_btn` mid-frame → `game_stop` stays 1 until the next `ft`; `atk_enable`=0x01 and `game_on`=1 one cycle after that `ft`.
3. Run PLAY with no `atk_over` for 300 frames (`SPAWN_FRAMES`=60) → `atk_enable` goes 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F and holds at 0x3F; `score`=300.
4. Run 4200 frames (`LEVEL_FRAMES`=600) → `level` steps every 600 frames and saturates at 7; force `score` near 0xFFFF → `score` saturates at 0xFFFF.
5. During PLAY, raise `atk_over`:
   - bit 5 while `atk_enable`=0x03 → ignored.
   - bit 0 coincident with `ft` → state OVER, `game_on`=0 next cycle, `score` not incremented.
   - then `st` → ARM with `game_stop`=1 and `level`=0, `score`=0, `atk_enable`=0.
6. Assert `clear` mid-PLAY for 1 cycle, asynchronously to the clock edge → all outputs at reset values immediately, state IDLE.
